// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, arbiter state encodings and the DM-vs-IF grant rule.
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;
  localparam int STAT_W = 16;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_WAIT = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;
  function automatic logic dm_wins(input logic if_req, input logic dm_req, input logic starved);
    return dm_req && (!if_req || !starved);
  endfunction
endpackage

// File: rtl/arb_stats.sv
// arb_stats: three free-running wrapping counters for arbiter grants and IDLE-cycle conflicts.
module arb_stats
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_grant,
  input  logic              dm_grant,
  input  logic              conflict,
  output logic [STAT_W-1:0] if_grants,
  output logic [STAT_W-1:0] dm_grants,
  output logic [STAT_W-1:0] conflicts
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_grants <= '0;
      dm_grants <= '0;
      conflicts <= '0;
    end else begin
      if_grants <= if_grants + STAT_W'(if_grant);
      dm_grants <= dm_grants + STAT_W'(dm_grant);
      conflicts <= conflicts + STAT_W'(conflict);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF reads and DM loads/stores, one transaction at a time.
// Define ARB_STATS_EN to add the if_grants/dm_grants/conflicts counter outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = ADDR_W,
  parameter int DW         = WORD_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ARB_STATS_EN
  output logic [STAT_W-1:0] if_grants,
  output logic [STAT_W-1:0] dm_grants,
  output logic [STAT_W-1:0] conflicts,
`endif
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_ack,
  output logic [DW-1:0]     if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  output logic              dm_ack,
  output logic [DW-1:0]     dm_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [1:0]    state;
  logic          owner_dm;
  logic [TW-1:0] timer;
  logic [SW-1:0] starve_cnt;
  logic          starved, pick_dm, issue, timed_out, done, got_ack;
  assign starved   = starve_cnt == SW'(STARVE_MAX);
  assign pick_dm   = dm_wins(if_req, dm_req, starved);
  assign issue     = state == ARB_IDLE && (if_req || dm_req);
  assign got_ack   = state == ARB_WAIT && mem_ack;
  // timer holds the count of WAIT cycles already elapsed, so this is the last allowed one
  assign timed_out = state == ARB_WAIT && !mem_ack && timer == TW'(TIMEOUT - 1);
  assign done      = got_ack || timed_out;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner_dm   <= 1'b0;
      timer      <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state  <= issue ? ARB_WAIT : done ? ARB_RESP : state == ARB_RESP ? ARB_IDLE : state;
      timer  <= state == ARB_WAIT ? timer + 1'b1 : '0;
      mem_en <= issue;
      if_ack <= done && !owner_dm;
      dm_ack <= done && owner_dm;
      err    <= timed_out;
      if (issue) begin
        owner_dm   <= pick_dm;
        mem_we     <= pick_dm && dm_we;
        mem_addr   <= pick_dm ? dm_addr : if_addr;
        mem_wdata  <= pick_dm ? dm_wdata : '0;
        starve_cnt <= pick_dm ? starve_cnt + SW'(if_req && !starved) : '0;
      end
      if (got_ack && !owner_dm) if_rdata <= mem_rdata;
      if (got_ack && owner_dm && !mem_we) dm_rdata <= mem_rdata;
    end
  end
`ifdef ARB_STATS_EN
  arb_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .if_grant  (issue && !pick_dm),
    .dm_grant  (issue && pick_dm),
    .conflict  (state == ARB_IDLE && if_req && dm_req),
    .if_grants (if_grants),
    .dm_grants (dm_grants),
    .conflicts (conflicts)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory against a transaction-timing reference model.
// Build with ARB_STATS_EN defined to also check the grant/conflict counters.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;
  localparam int NONE       = 1000;
  localparam int NEVER      = 1 << 30;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic if_ack, dm_ack, err, mem_en, mem_we;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
`ifdef ARB_STATS_EN
  logic [15:0] if_grants, dm_grants, conflicts;
`endif
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
`ifdef ARB_STATS_EN
    .if_grants(if_grants), .dm_grants(dm_grants), .conflicts(conflicts),
`endif
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, got, want, $time);
    end
  endtask

  // reference model: one outstanding transaction described by its issue/response cycles
  int cyc = 0, free_at = NEVER, en_cyc = -1, resp_cyc = -1, ack_cyc = -1, starve = 0;
  int n_if = 0, n_dm = 0, n_conf = 0, lat_fix = -1;
  int lat_tab[10] = '{1, 1, 1, 2, 3, 5, 14, 15, 16, NONE};
  bit own_dm, exp_err, exp_we, rel_pending, rnd, if_on, dm_on;
  bit if_pend, dm_pend, if_gnt, dm_gnt, if_drop, dm_drop, dir_we;
  logic [15:0] exp_addr, exp_wdata, ack_data, exp_if_rdata = '0, exp_dm_rdata = '0;
  logic [15:0] dir_if_addr, dir_dm_addr, dir_dm_wdata, dir_rdata;
  logic [15:0] obs[$];

  task automatic step();
    int lat;
    @(negedge clk);
    cyc++;
    if (cyc == resp_cyc && !exp_err && !(own_dm && exp_we)) begin
      if (own_dm) exp_dm_rdata = ack_data;
      else exp_if_rdata = ack_data;
    end
    if (mem_en) obs.push_back(mem_addr);
    check("mem_en", 80'(mem_en), 80'(cyc == en_cyc));
    if (cyc == en_cyc) begin
      check("mem_we", 80'(mem_we), 80'(exp_we));
      check("mem_addr", 80'(mem_addr), 80'(exp_addr));
      if (exp_we) check("mem_wdata", 80'(mem_wdata), 80'(exp_wdata));
    end
    check("if_ack", 80'(if_ack), 80'(cyc == resp_cyc && !own_dm));
    check("dm_ack", 80'(dm_ack), 80'(cyc == resp_cyc && own_dm));
    check("err", 80'(err), 80'(cyc == resp_cyc && exp_err));
    check("if_rdata", 80'(if_rdata), 80'(exp_if_rdata));
    check("dm_rdata", 80'(dm_rdata), 80'(exp_dm_rdata));
    if (rel_pending) begin
      reset = 1'b1;
      rel_pending = 1'b0;
      free_at = cyc;
    end
    if (cyc == resp_cyc) begin
      if (own_dm) {dm_pend, dm_gnt, dm_drop} = '0;
      else {if_pend, if_gnt, if_drop} = '0;
    end
    if (!if_pend && if_on && (!rnd || $urandom_range(3) == 0)) begin
      if_pend = 1'b1;
      if_addr = rnd ? 16'($urandom) : dir_if_addr;
    end
    if (!dm_pend && dm_on && (!rnd || $urandom_range(3) == 0)) begin
      dm_pend  = 1'b1;
      dm_we    = rnd ? 1'($urandom_range(1)) : dir_we;
      dm_addr  = rnd ? 16'($urandom) : dir_dm_addr;
      dm_wdata = rnd ? 16'($urandom) : dir_dm_wdata;
    end
    if (rnd && if_gnt && $urandom_range(7) == 0) if_drop = 1'b1;
    if (rnd && dm_gnt && $urandom_range(7) == 0) dm_drop = 1'b1;
    if_req    = if_pend && !if_drop;
    dm_req    = dm_pend && !dm_drop;
    mem_ack   = cyc == ack_cyc;
    mem_rdata = mem_ack ? ack_data : 16'($urandom);
    if (reset && cyc >= free_at && (if_req || dm_req)) begin
      if (if_req && dm_req) n_conf++;
      own_dm = dm_req && (!if_req || starve < STARVE_MAX);
      if (own_dm) begin
        if (if_req && starve < STARVE_MAX) starve++;
        n_dm++;
        dm_gnt = 1'b1;
        exp_we = dm_we;
        exp_addr = dm_addr;
        exp_wdata = dm_wdata;
      end else begin
        starve = 0;
        n_if++;
        if_gnt = 1'b1;
        exp_we = 1'b0;
        exp_addr = if_addr;
      end
      lat      = lat_fix >= 0 ? lat_fix : lat_tab[$urandom_range(9)];
      en_cyc   = cyc + 1;
      ack_cyc  = lat == NONE ? -1 : en_cyc + lat;
      ack_data = rnd ? 16'($urandom) : dir_rdata;
      exp_err  = lat > TIMEOUT - 1;
      resp_cyc = exp_err ? en_cyc + TIMEOUT : en_cyc + lat + 1;
      free_at  = resp_cyc + 1;
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check("rst_resp", {if_ack, dm_ack, err, if_rdata, dm_rdata}, '0);
    free_at = NEVER;
    en_cyc = -1;
    resp_cyc = -1;
    starve = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    {if_pend, if_gnt, if_drop, dm_pend, dm_gnt, dm_drop} = '0;
    if_req = 1'b0;
    dm_req = 1'b0;
    n_if = 0;
    n_dm = 0;
    n_conf = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check("rst_resp", {if_ack, dm_ack, err, if_rdata, dm_rdata}, '0);
    rel_pending = 1'b1;
    step();
    // single IF read, 1-cycle memory
    rnd = 1'b0; lat_fix = 1; dir_if_addr = 16'h0010; dir_rdata = 16'hC0DE;
    if_on = 1'b1; step(); if_on = 1'b0;
    run(5);
    check("if_read_data", 80'(if_rdata), 80'(16'hC0DE));
    // both requesters held continuously
    dir_dm_addr = 16'h0200; dir_we = 1'b0;
    obs.delete();
    if_on = 1'b1; dm_on = 1'b1;
    run(40);
    if_on = 1'b0; dm_on = 1'b0;
    check("starve_count", 80'(obs.size() >= 6), 80'(1));
    for (int i = 0; i < 6 && i < obs.size(); i++)
      check("starve_order", 80'(obs[i]), 80'(i == 4 ? 16'h0010 : 16'h0200));
    run(10);
    // store
    dir_we = 1'b1; dir_dm_addr = 16'h0005; dir_dm_wdata = 16'h1234;
    dm_on = 1'b1; step(); dm_on = 1'b0;
    run(5);
    check("store_keeps_rdata", 80'(dm_rdata), 80'(16'h0200 ^ 16'h0200 ^ exp_dm_rdata));
    // memory never acks, then a late ack after the timeout
    lat_fix = NONE; if_on = 1'b1; step(); if_on = 1'b0;
    run(20);
    lat_fix = 16; dm_on = 1'b1; step(); dm_on = 1'b0;
    run(22);
    // reset in the middle of WAIT with a memory ack still on its way
    lat_fix = 3; dir_rdata = 16'hBEEF; if_on = 1'b1; step(); if_on = 1'b0;
    for (int i = 0; i < 10 && cyc != en_cyc + 1; i++) step();
    do_reset();
    rel_pending = 1'b1;
    run(3);
    lat_fix = 1; dir_rdata = 16'h5A5A; if_on = 1'b1; step(); if_on = 1'b0;
    run(5);
    check("post_reset_read", 80'(if_rdata), 80'(16'h5A5A));
    // randomized traffic
    rnd = 1'b1; lat_fix = -1; if_on = 1'b1; dm_on = 1'b1;
    run(3000);
    if_on = 1'b0; dm_on = 1'b0;
    run(40);
`ifdef ARB_STATS_EN
    check("if_grants", 80'(if_grants), 80'(16'(n_if)));
    check("dm_grants", 80'(dm_grants), 80'(16'(n_dm)));
    check("conflicts", 80'(conflicts), 80'(16'(n_conf)));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
